// File: rtl/empaquetador_pixeles_mem_pkg.sv
// Shared constants and types for the pixel packer and the pixel read buffer.
// Both blocks use the same MSB-first lane order and state encoding.
package empaquetador_pixeles_mem_pkg;

    localparam int unsigned DEF_MEM_WORD_BITS   = 32;
    localparam int unsigned DEF_PIXEL_BITS      = 8;
    localparam int unsigned DEF_PIXELS_PER_WORD = DEF_MEM_WORD_BITS / DEF_PIXEL_BITS;

    typedef enum logic [1:0] {
        E_VACIO = 2'd0,
        E_UNO   = 2'd1,
        E_LLENO = 2'd2
    } estado_t;

    // Lane k occupies [lane_lsb + PIXEL_BITS - 1 : lane_lsb]; lane 0 is the MSB lane.
    function automatic int unsigned lane_lsb(input int unsigned word_bits,
                                             input int unsigned pix_bits,
                                             input int unsigned k);
        return word_bits - pix_bits * (k + 1);
    endfunction

endpackage

// File: rtl/empaquetador_pixeles_mem_ranura_palabra.sv
// One word slot of the ping-pong pair: lane writes, zero-pad on close,
// clear on consume. Exposes both the registered word and its next value.
module ranura_palabra
    import empaquetador_pixeles_mem_pkg::*;
#(
    parameter int unsigned MEM_WORD_BITS = DEF_MEM_WORD_BITS,
    parameter int unsigned PIXEL_BITS    = DEF_PIXEL_BITS,
    parameter int unsigned LANE_W        = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [LANE_W-1:0]        lane,
    input  logic [PIXEL_BITS-1:0]    pixel,
    input  logic                     close,
    input  logic [LANE_W:0]          keep,
    input  logic                     clear,
    output logic [MEM_WORD_BITS-1:0] word_q,
    output logic                     full_q,
    output logic [MEM_WORD_BITS-1:0] word_c
);

    localparam int unsigned PIXELS_PER_WORD = MEM_WORD_BITS / PIXEL_BITS;
    localparam int unsigned KEEP_W          = LANE_W + 1;

    logic [MEM_WORD_BITS-1:0] word_d;
    logic                     full_d;

    // Pixel write happens before the pad, so a closing pixel survives the pad.
    always_comb begin
        word_d = word_q;
        full_d = full_q;
        if (clear) begin
            word_d = '0;
            full_d = 1'b0;
        end else begin
            for (int i = 0; i < int'(PIXELS_PER_WORD); i++) begin
                if (wr_en && (lane == LANE_W'(i))) begin
                    word_d[lane_lsb(MEM_WORD_BITS, PIXEL_BITS, i) +: PIXEL_BITS] = pixel;
                end
            end
            if (close) begin
                for (int i = 0; i < int'(PIXELS_PER_WORD); i++) begin
                    if (KEEP_W'(i) >= keep) begin
                        word_d[lane_lsb(MEM_WORD_BITS, PIXEL_BITS, i) +: PIXEL_BITS] = '0;
                    end
                end
                full_d = 1'b1;
            end
        end
    end

    assign word_c = word_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/empaquetador_pixeles_mem.sv
// Packs filter pixels MSB-first into memory words through an A/B slot pair
// and hands finished words to the memory writer with a valid/taken handshake.
module empaquetador_pixeles_mem
    import empaquetador_pixeles_mem_pkg::*;
#(
    parameter int unsigned MEM_WORD_BITS = DEF_MEM_WORD_BITS,
    parameter int unsigned PIXEL_BITS    = DEF_PIXEL_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PIXEL_BITS-1:0]    pixel_in,
    input  logic                     pixel_valid,
    output logic                     pixel_ready,
    input  logic                     flush,
    output logic [MEM_WORD_BITS-1:0] memory_data,
    output logic                     word_valid,
    input  logic                     word_taken
);

    localparam int unsigned PIXELS_PER_WORD = MEM_WORD_BITS / PIXEL_BITS;
    localparam int unsigned KW     = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
    localparam int unsigned KEEP_W = KW + 1;

    estado_t                  state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic                     fill_ptr_q, fill_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic                     flush_pend_q, flush_pend_d;
    logic                     pixel_ready_q, pixel_ready_d;
    logic                     word_valid_q, word_valid_d;
    logic [MEM_WORD_BITS-1:0] memory_data_q, memory_data_d;

    logic                     accept, consume, flush_req, last_lane;
    logic                     pixel_close, flush_close, close, fill_full;
    logic [KEEP_W-1:0]        keep;

    logic [MEM_WORD_BITS-1:0] word_a_q, word_b_q, word_a_c, word_b_c;
    logic                     full_a_q, full_b_q;

    always_comb begin
        fill_full = fill_ptr_q ? full_b_q : full_a_q;
        accept    = pixel_valid && pixel_ready_q && !fill_full;
        consume   = word_valid_q && word_taken;
        flush_req = flush || flush_pend_q;
        last_lane = (k_q == KW'(PIXELS_PER_WORD - 1));

        // A lane-3 pixel already completes the word; a flush alongside it adds nothing.
        pixel_close = accept && last_lane;
        flush_close = pixel_ready_q && flush_req && (accept || (k_q != '0)) && !pixel_close;
        close       = pixel_close || flush_close;
        keep        = KEEP_W'(k_q) + KEEP_W'(accept);

        // A flush that arrives while both slots are full waits for a free slot.
        flush_pend_d = !pixel_ready_q && flush_req;

        k_d = k_q;
        if (close) begin
            k_d = '0;
        end else if (accept) begin
            k_d = k_q + KW'(1);
        end

        fill_ptr_d = fill_ptr_q ^ close;
        rd_ptr_d   = rd_ptr_q ^ consume;

        state_d = state_q;
        case (state_q)
            E_VACIO: if (close) state_d = E_UNO;
            E_UNO: begin
                if (close && !consume) begin
                    state_d = E_LLENO;
                end else if (consume && !close) begin
                    state_d = E_VACIO;
                end
            end
            E_LLENO: if (consume && !close) state_d = E_UNO;
            default: state_d = E_VACIO;
        endcase

        pixel_ready_d = (state_d != E_LLENO);
        word_valid_d  = (state_d != E_VACIO);
        memory_data_d = rd_ptr_d ? word_b_c : word_a_c;
    end

    ranura_palabra #(
        .MEM_WORD_BITS (MEM_WORD_BITS),
        .PIXEL_BITS    (PIXEL_BITS),
        .LANE_W        (KW)
    ) u_ranura_a (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (accept && !fill_ptr_q),
        .lane   (k_q),
        .pixel  (pixel_in),
        .close  (close && !fill_ptr_q),
        .keep   (keep),
        .clear  (consume && !rd_ptr_q),
        .word_q (word_a_q),
        .full_q (full_a_q),
        .word_c (word_a_c)
    );

    ranura_palabra #(
        .MEM_WORD_BITS (MEM_WORD_BITS),
        .PIXEL_BITS    (PIXEL_BITS),
        .LANE_W        (KW)
    ) u_ranura_b (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (accept && fill_ptr_q),
        .lane   (k_q),
        .pixel  (pixel_in),
        .close  (close && fill_ptr_q),
        .keep   (keep),
        .clear  (consume && rd_ptr_q),
        .word_q (word_b_q),
        .full_q (full_b_q),
        .word_c (word_b_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= E_VACIO;
            k_q           <= '0;
            fill_ptr_q    <= 1'b0;
            rd_ptr_q      <= 1'b0;
            flush_pend_q  <= 1'b0;
            pixel_ready_q <= 1'b1;
            word_valid_q  <= 1'b0;
            memory_data_q <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            fill_ptr_q    <= fill_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            flush_pend_q  <= flush_pend_d;
            pixel_ready_q <= pixel_ready_d;
            word_valid_q  <= word_valid_d;
            memory_data_q <= memory_data_d;
        end
    end

    assign pixel_ready = pixel_ready_q;
    assign word_valid  = word_valid_q;
    assign memory_data = memory_data_q;

endmodule

// File: tb/tb_empaquetador_pixeles_mem.sv
// Bench for empaquetador_pixeles_mem: a packing model feeds a queue of expected
// words, which are popped and compared each time the writer takes a word.
module tb_empaquetador_pixeles_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        flush;
    logic [31:0] memory_data;
    logic        word_valid;
    logic        word_taken;

    logic [31:0] exp_q[$];
    logic [31:0] m_word;
    int          m_k;
    int          total;
    int          bad;

    always #5 clk = ~clk;

    empaquetador_pixeles_mem dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .flush       (flush),
        .memory_data (memory_data),
        .word_valid  (word_valid),
        .word_taken  (word_taken)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] p);
        m_word[(31 - 8 * m_k) -: 8] = p;
        m_k++;
        if (m_k == 4) begin
            exp_q.push_back(m_word);
            m_word = '0;
            m_k    = 0;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_word = '0;
        m_k    = 0;
    endtask

    // Holds the pixel until accepted; inputs change 1 time unit after the rising edge.
    task automatic send_pixel(input logic [7:0] p, input bit chk_ready);
        pixel_in    = p;
        pixel_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (chk_ready) check("ready_burst", 32'(pixel_ready), 32'd1);
            if (pixel_ready) begin
                model_accept(p);
                @(posedge clk);
                #1;
                pixel_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("accept_timeout", 32'(pixel_ready), 32'd1);
        pixel_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        if (pixel_ready && m_k > 0) begin
            exp_q.push_back(m_word);
            m_word = '0;
            m_k    = 0;
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every consumed word must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && word_valid && word_taken) begin
            if (exp_q.size() == 0) begin
                check("extra_word", memory_data, 32'hxxxx_xxxx);
            end else begin
                check("word", memory_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        total       = 0;
        bad         = 0;
        m_word      = '0;
        m_k         = 0;
        reset       = 1'b1;
        pixel_in    = '0;
        pixel_valid = 1'b0;
        flush       = 1'b0;
        word_taken  = 1'b0;
        idle(2);
        reset = 1'b0;

        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_data", memory_data, 32'h0);
        check("rst_ready", 32'(pixel_ready), 32'd1);

        // First word, writer not taking.
        send_pixel(8'h11, 1'b0);
        send_pixel(8'h22, 1'b0);
        send_pixel(8'h33, 1'b0);
        send_pixel(8'h44, 1'b0);
        check("w1_valid", 32'(word_valid), 32'd1);
        check("w1_data", memory_data, 32'h11223344);
        check("w1_ready", 32'(pixel_ready), 32'd1);

        // Second word fills both slots.
        send_pixel(8'h55, 1'b0);
        send_pixel(8'h66, 1'b0);
        send_pixel(8'h77, 1'b0);
        send_pixel(8'h88, 1'b0);
        check("full_ready", 32'(pixel_ready), 32'd0);
        check("full_data", memory_data, 32'h11223344);

        // A held pixel must not enter while both slots are full.
        pixel_in    = 8'h99;
        pixel_valid = 1'b1;
        idle(3);
        check("held_ready", 32'(pixel_ready), 32'd0);
        check("held_data", memory_data, 32'h11223344);
        check("held_valid", 32'(word_valid), 32'd1);

        word_taken = 1'b1;
        idle(1);
        word_taken = 1'b0;
        check("take1_data", memory_data, 32'h55667788);
        check("take1_valid", 32'(word_valid), 32'd1);
        check("take1_ready", 32'(pixel_ready), 32'd1);
        send_pixel(8'h99, 1'b0);

        word_taken = 1'b1;
        idle(1);
        word_taken = 1'b0;
        check("take2_valid", 32'(word_valid), 32'd0);

        // Flushes: partial words zero-padded, flush at lane 0 ignored.
        word_taken = 1'b1;
        do_flush();
        send_pixel(8'hAA, 1'b0);
        send_pixel(8'hBB, 1'b0);
        do_flush();
        send_pixel(8'hCC, 1'b0);
        send_pixel(8'hDD, 1'b0);
        send_pixel(8'hEE, 1'b0);
        send_pixel(8'hFF, 1'b0);
        do_flush();
        idle(5);
        check("drain1", 32'(exp_q.size()), 32'd0);
        check("drain1_valid", 32'(word_valid), 32'd0);

        // Sustained stream with the writer always taking.
        for (int i = 0; i < 64; i++) begin
            send_pixel(8'(i), 1'b1);
        end
        idle(6);
        check("drain2", 32'(exp_q.size()), 32'd0);

        // Reset mid-word with a complete word still pending.
        word_taken = 1'b0;
        send_pixel(8'hB1, 1'b0);
        send_pixel(8'hB2, 1'b0);
        send_pixel(8'hB3, 1'b0);
        send_pixel(8'hB4, 1'b0);
        send_pixel(8'hC1, 1'b0);
        send_pixel(8'hC2, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        model_clear();
        check("mrst_valid", 32'(word_valid), 32'd0);
        check("mrst_data", memory_data, 32'h0);
        check("mrst_ready", 32'(pixel_ready), 32'd1);

        send_pixel(8'hA1, 1'b0);
        send_pixel(8'hA2, 1'b0);
        send_pixel(8'hA3, 1'b0);
        send_pixel(8'hA4, 1'b0);
        check("post_rst_valid", 32'(word_valid), 32'd1);
        check("post_rst_data", memory_data, 32'hA1A2A3A4);
        word_taken = 1'b1;
        idle(3);
        word_taken = 1'b0;
        check("drain3", 32'(exp_q.size()), 32'd0);
        check("drain3_valid", 32'(word_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
